// File: rtl/csa_cpa_resolve.sv
// csa_cpa_resolve: multi-cycle carry-propagate adder that folds a redundant
// sum/carry pair (carry has weight 2) into one exact binary result of
// WIDTH+2 bits, CHUNK bits per clock, behind valid/ready handshakes.
module csa_cpa_resolve #(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int RW     = WIDTH + 2,
    localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK,
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   a_q, a_d;
    logic [RW-1:0]   b_q, b_d;
    logic [RW-1:0]   res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;

    logic [31:0]     shamt;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum_c;
    logic [RW-1:0]   chunk_mask;
    logic [RW-1:0]   chunk_ins;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, walk chunks in BUSY, wait for
    // downstream acceptance in DONE.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid)           state_d = S_BUSY;
            S_BUSY: if (idx_q == LAST_IDX)  state_d = S_DONE;
            S_DONE: if (out_ready)          state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Handshake outputs come from the state register alone.
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        busy       = (state_q == S_BUSY) || (state_q == S_DONE);
        out_result = res_q;
    end

    // Chunk adder: select the current CHUNK slice of both operands, add with
    // the registered carry, and merge the sum bits into the result. Slice
    // bits above RW shift out of range, so a partial last chunk reads zeros
    // and its excess sum bits are discarded.
    always_comb begin
        shamt      = 32'(idx_q) * CHUNK;
        a_chunk    = CHUNK'(a_q >> shamt);
        b_chunk    = CHUNK'(b_q >> shamt);
        sum_c      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        chunk_mask = RW'({CHUNK{1'b1}}) << shamt;
        chunk_ins  = RW'(sum_c[CHUNK-1:0]) << shamt;
    end

    // Datapath next values: latch operands on acceptance, accumulate in BUSY.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = {2'b00, in_sum};
                    b_d     = {1'b0, in_carry, 1'b0};
                    res_d   = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            S_BUSY: begin
                res_d   = (res_q & ~chunk_mask) | chunk_ins;
                carry_d = sum_c[CHUNK];
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers; an in-flight operation is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_csa_cpa_resolve.sv
// Bench for csa_cpa_resolve: directed vectors, backpressure and reset
// sequences on a CHUNK=8 instance, plus randomized streams through a
// behavioural 3:2 compressor on CHUNK = 8, 1, 5 and 34 instances.
module tb_csa_cpa_resolve;

    localparam int W  = 32;
    localparam int RW = W + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Index 0..3 -> CHUNK 8, 1, 5, 34.
    logic [3:0]          iv, ir, ov, ordy, bz;
    logic [3:0][W-1:0]   isum, icar;
    logic [3:0][RW-1:0]  ores;
    int nck [4] = '{5, 34, 7, 1};

    csa_cpa_resolve #(.WIDTH(W), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_sum(isum[0]), .in_carry(icar[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_result(ores[0]), .busy(bz[0]));
    csa_cpa_resolve #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_sum(isum[1]), .in_carry(icar[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_result(ores[1]), .busy(bz[1]));
    csa_cpa_resolve #(.WIDTH(W), .CHUNK(5)) u_c5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_sum(isum[2]), .in_carry(icar[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_result(ores[2]), .busy(bz[2]));
    csa_cpa_resolve #(.WIDTH(W), .CHUNK(34)) u_c34 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_sum(isum[3]), .in_carry(icar[3]), .out_valid(ov[3]),
        .out_ready(ordy[3]), .out_result(ores[3]), .busy(bz[3]));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0]  s;
        logic [W-1:0]  c;
        logic [RW-1:0] r;
    } vec_t;
    vec_t tbl [7];

    // One transaction on the CHUNK=8 instance with exact latency checks.
    task automatic do_op(input string nm, input logic [W-1:0] s, input logic [W-1:0] c,
                         input logic [RW-1:0] exp);
        @(negedge clk);
        check({nm, "_in_ready_idle"}, ir[0], 1);
        isum[0] = s; icar[0] = c; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int cy = 1; cy <= 5; cy++) begin
            @(posedge clk); #1;
            check($sformatf("%s_out_valid_c%0d", nm, cy), ov[0], (cy == 5));
            check($sformatf("%s_in_ready_c%0d", nm, cy), ir[0], 0);
        end
        check({nm, "_result"}, ores[0], exp);
        check({nm, "_busy_done"}, bz[0], 1);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check({nm, "_out_valid_after"}, ov[0], 0);
        check({nm, "_in_ready_after"}, ir[0], 1);
        check({nm, "_busy_after"}, bz[0], 0);
    endtask

    // Continuous traffic: in_valid and out_ready held high on instance k.
    // Expected results come from plain arithmetic on the operands; when
    // chained, operands come from a behavioural 3:2 compressor.
    task automatic stream(input int k, input int n, input bit chained);
        logic [RW-1:0] expq [$];
        logic [RW-1:0] nexp;
        logic [W-1:0] x0, x1, x2;
        int cyc, acc_cyc, sent, got, budget;
        bit acc, ret;
        cyc = 0; acc_cyc = -1; sent = 0; got = 0;
        budget = n * (nck[k] + 2) + 50;
        x0 = $urandom; x1 = $urandom; x2 = $urandom;
        if (chained) begin
            isum[k] = x0 ^ x1 ^ x2;
            icar[k] = (x0 & x1) | (x0 & x2) | (x1 & x2);
            nexp = RW'(x0) + RW'(x1) + RW'(x2);
        end else begin
            isum[k] = x0; icar[k] = x1;
            nexp = RW'(x0) + 2 * RW'(x1);
        end
        iv[k] = 1'b1; ordy[k] = 1'b1;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            acc = iv[k] & ir[k];
            ret = ov[k] & ordy[k];
            if (ret) begin
                if (expq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stream%0d_order: result 0x%0h with none pending", k, ores[k]);
                end else begin
                    check($sformatf("stream%0d_result%0d", k, got), ores[k], expq.pop_front());
                end
                got++;
            end
            if (acc) begin
                expq.push_back(nexp);
                sent++;
                if (acc_cyc >= 0)
                    check($sformatf("stream%0d_spacing", k), cyc - acc_cyc, nck[k] + 2);
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (sent < n) begin
                    x0 = $urandom; x1 = $urandom; x2 = $urandom;
                    if (chained) begin
                        isum[k] = x0 ^ x1 ^ x2;
                        icar[k] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                        nexp = RW'(x0) + RW'(x1) + RW'(x2);
                    end else begin
                        isum[k] = x0; icar[k] = x1;
                        nexp = RW'(x0) + 2 * RW'(x1);
                    end
                end else begin
                    iv[k] = 1'b0;
                end
            end
        end
        if (got < n) check($sformatf("stream%0d_timeout", k), got, n);
        iv[k] = 1'b0; ordy[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 34'h0_0000_000B};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 34'h0_FFFF_FFFF};
        tbl[3] = '{32'h0000_0001, 32'h7FFF_FFFF, 34'h0_FFFF_FFFF};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 34'h0_0000_0000};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 34'h1_8000_0000};
        tbl[6] = '{32'h1234_5678, 32'h0101_0101, 34'h0_1436_587A};

        rst_n = 1'b0;
        iv = '0; ordy = '0; isum = '0; icar = '0;
        #12;
        check("reset_in_ready", ir[0], 1);
        check("reset_out_valid", ov[0], 0);
        check("reset_out_result", ores[0], 0);
        check("reset_busy", bz[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].c, tbl[i].r);

        // Backpressure: hold out_ready low for 10 cycles with a competing pair.
        @(negedge clk);
        isum[0] = 32'h5; icar[0] = 32'h3; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        isum[0] = 32'hDEAD_BEEF; icar[0] = 32'h1234_5678;
        repeat (5) @(posedge clk);
        #1;
        for (int cy = 0; cy < 10; cy++) begin
            check("bp_out_valid", ov[0], 1);
            check("bp_result", ores[0], 34'hB);
            check("bp_in_ready", ir[0], 0);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp_release_out_valid", ov[0], 0);
        check("bp_release_in_ready", ir[0], 1);
        @(posedge clk); #1;
        check("bp_not_consumed_in_ready", ir[0], 1);
        check("bp_not_consumed_busy", bz[0], 0);

        // Reset while in BUSY at idx=2.
        @(negedge clk);
        isum[0] = 32'hFFFF_FFFF; icar[0] = 32'hFFFF_FFFF; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", ir[0], 1);
        check("rst_mid_out_valid", ov[0], 0);
        check("rst_mid_out_result", ores[0], 0);
        check("rst_mid_busy", bz[0], 0);
        ordy[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 32'h10, 32'h08, 34'h20);

        // Back-to-back plain pairs, then chained random traffic per CHUNK.
        stream(0, 20, 1'b0);
        for (int k = 0; k < 4; k++) stream(k, 250, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
